// File: rtl/add_tree_pkg.sv
// ---------------------------------------------------------------------------
// add_tree_pkg
// Shared width helpers for the pipelined adder tree (add_tree_pipe) and its
// per-level reduction cell (add_tree_level).
//   clog2(n)          ceiling log2, used for the level count
//   in_w(xlen)        operand width 2*XLEN+1
//   lvl_w(xlen, k)    width of the registered sums held by level k
//   out_w(xlen,n,acc) width of result_o for the current build
// The optional output accumulator is selected by the ADD_TREE_ACC_EN macro.
// ---------------------------------------------------------------------------
package add_tree_pkg;

`ifdef ADD_TREE_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int in_w(input int xlen);
        return 2 * xlen + 1;
    endfunction

    // Each level adds one bit so the tree can never overflow.
    function automatic int lvl_w(input int xlen, input int k);
        return in_w(xlen) + k + 1;
    endfunction

    function automatic int out_w(input int xlen, input int nr, input int acc_w);
        return ACC_EN ? acc_w : in_w(xlen) + clog2(nr);
    endfunction

endpackage

// File: rtl/add_tree_level.sv
// ---------------------------------------------------------------------------
// add_tree_level
// One registered N -> N/2 pairwise reduction level. Sums are unsigned and one
// bit wider than the operands, so they are exact.
//   clk_i   clock
//   hold_i  keep current contents (global stall)
//   clr_i   clear valid/last and data (reset / flush / disable)
//   vld_i, last_i   sidebands entering with a_i
//   a_i     N operands of width IW
//   vld_o, last_o   registered sidebands
//   sum_o   N/2 registered sums of width IW+1
// ---------------------------------------------------------------------------
module add_tree_level
    import add_tree_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 8
) (
    input  logic          clk_i,
    input  logic          hold_i,
    input  logic          clr_i,
    input  logic          vld_i,
    input  logic          last_i,
    input  logic [IW-1:0] a_i   [N],
    output logic          vld_o,
    output logic          last_o,
    output logic [IW:0]   sum_o [N/2]
);

    logic        vld_p1;
    logic        last_p1;
    logic [IW:0] sum_p1 [N/2];

    // Stage boundary: operands -> pairwise sums
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            for (int i = 0; i < N / 2; i++) sum_p1[i] <= '0;
        end else if (!hold_i) begin
            vld_p1  <= vld_i;
            last_p1 <= last_i;
            for (int i = 0; i < N / 2; i++)
                sum_p1[i] <= {1'b0, a_i[2*i]} + {1'b0, a_i[2*i+1]};
        end
    end

    assign vld_o  = vld_p1;
    assign last_o = last_p1;
    assign sum_o  = sum_p1;

endmodule

// File: rtl/add_tree_pipe.sv
// ---------------------------------------------------------------------------
// add_tree_pipe
// Reduces NR_INPUTS unsigned operands to one sum through a registered
// log2(NR_INPUTS)-level adder tree with valid/ready backpressure. Optional
// multi-beat output accumulator, compiled in with macro ADD_TREE_ACC_EN.
//   clk_i     clock
//   rst_i     synchronous reset, active-high
//   en_i      block enable; low acts like flush_i
//   flush_i   discard in-flight data and the accumulator
//   valid_i / ready_o   input handshake; a_i = NR_INPUTS operands
//   last_i    final beat of an accumulation group (accumulator build only)
//   valid_o / ready_i   output handshake; result_o = sum
//   ovf_o     sticky accumulator wrap flag (0 without the accumulator)
// A stalled output (valid_o & ~ready_i) freezes every stage at once.
// ---------------------------------------------------------------------------
module add_tree_pipe
    import add_tree_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NR_INPUTS = 32,
    parameter int ACC_W     = 2 * XLEN + 1 + 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     en_i,
    input  logic                                     flush_i,
    input  logic                                     valid_i,
    output logic                                     ready_o,
    input  logic [in_w(XLEN)-1:0]                    a_i [NR_INPUTS],
    input  logic                                     last_i,
    output logic                                     valid_o,
    input  logic                                     ready_i,
    output logic [out_w(XLEN, NR_INPUTS, ACC_W)-1:0] result_o,
    output logic                                     ovf_o
);

    localparam int IN_W = in_w(XLEN);
    localparam int LVL  = clog2(NR_INPUTS);
    localparam int TW   = lvl_w(XLEN, LVL - 1);

    if (NR_INPUTS < 2 || (NR_INPUTS & (NR_INPUTS - 1)) != 0) begin : g_bad_nr
        $error("add_tree_pipe: NR_INPUTS must be a power of two >= 2");
    end

    logic stall;
    logic clr;

    assign stall   = valid_o & ~ready_i;
    assign ready_o = ~stall & en_i & ~rst_i;
    assign clr     = rst_i | flush_i | ~en_i;

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int NI = NR_INPUTS >> k;
        localparam int IW = IN_W + k;

        logic [IW-1:0] din  [NI];
        logic [IW:0]   dout [NI/2];
        logic          vin;
        logic          lin;
        logic          vout;
        logic          lout;

        if (k == 0) begin : g_src
            assign din = a_i;
            assign vin = valid_i & ready_o;
            assign lin = last_i;
        end else begin : g_src
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
            assign lin = g_lvl[k-1].lout;
        end

        add_tree_level #(
            .N  (NI),
            .IW (IW)
        ) u_level (
            .clk_i  (clk_i),
            .hold_i (stall),
            .clr_i  (clr),
            .vld_i  (vin),
            .last_i (lin),
            .a_i    (din),
            .vld_o  (vout),
            .last_o (lout),
            .sum_o  (dout)
        );
    end

    logic [TW-1:0] tree_sum;
    logic          tree_vld;
    logic          tree_last;

    assign tree_sum  = g_lvl[LVL-1].dout[0];
    assign tree_vld  = g_lvl[LVL-1].vout;
    assign tree_last = g_lvl[LVL-1].lout;

`ifdef ADD_TREE_ACC_EN
    // Sum is computed one bit wider than both terms; anything above ACC_W
    // is the wrap that feeds the sticky flag.
    localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;

    logic [ACC_W-1:0] acc_p1;
    logic             ovf_acc_p1;
    logic [ACC_W-1:0] res_p1;
    logic             vld_p1;
    logic             ovf_p1;
    logic [SW-1:0]    acc_sum;
    logic             acc_carry;

    always_comb begin
        acc_sum   = SW'(acc_p1) + SW'(tree_sum);
        acc_carry = |acc_sum[SW-1:ACC_W];
    end

    // Stage boundary: tree result -> accumulator / output register
    always_ff @(posedge clk_i) begin
        if (clr) begin
            acc_p1     <= '0;
            ovf_acc_p1 <= 1'b0;
            res_p1     <= '0;
            vld_p1     <= 1'b0;
            ovf_p1     <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= tree_vld & tree_last;
            if (tree_vld) begin
                ovf_p1 <= ovf_acc_p1 | acc_carry;
                if (tree_last) begin
                    res_p1     <= acc_sum[ACC_W-1:0];
                    acc_p1     <= '0;
                    ovf_acc_p1 <= 1'b0;
                end else begin
                    acc_p1     <= acc_sum[ACC_W-1:0];
                    ovf_acc_p1 <= ovf_acc_p1 | acc_carry;
                end
            end
        end
    end

    assign valid_o  = vld_p1;
    assign result_o = res_p1;
    assign ovf_o    = ovf_p1;
`else
    // The last sideband still rides the tree but has no consumer here.
    logic unused_last;
    assign unused_last = tree_last;

    assign valid_o  = tree_vld;
    assign result_o = tree_sum;
    assign ovf_o    = 1'b0;
`endif

endmodule
